// File: rtl/am2909_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : am2909_seq_pkg
// Brief    : Source-select and stack-operation encodings for am2909_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package am2909_seq_pkg;

   localparam logic [1:0] SRC_UPC = 2'b00;
   localparam logic [1:0] SRC_AR  = 2'b01;
   localparam logic [1:0] SRC_STK = 2'b10;
   localparam logic [1:0] SRC_D   = 2'b11;

   localparam logic PUP_PUSH = 1'b1;
   localparam logic PUP_POP  = 1'b0;

endpackage : am2909_seq_pkg
`default_nettype wire

// File: rtl/am2909_seq_stack.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : am2909_seq_stack
// Brief    : LIFO return-address stack with occupancy-based FULL/EMPTY and an
//            optional sticky misuse flag (macro AM2909_SEQ_STACK_ERR_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module am2909_seq_stack
   import am2909_seq_pkg::*;
#(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic         cp_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
`ifdef AM2909_SEQ_STACK_ERR_EN
   output logic         err_o,
`endif
   output logic         empty_o
);

   localparam int SPW = $clog2(DEPTH + 1);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SPW-1:0] sp_q, sp_d;
   logic [W-1:0]   mem_q [DEPTH];
   logic [IW-1:0]  wr_idx;
   logic [IW-1:0]  rd_idx;
   logic           do_push;
   logic           do_pop;

   assign full_o  = (sp_q == SPW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign wr_idx  = IW'(sp_q);
   assign rd_idx  = IW'(sp_q - 1'b1);
   assign top_o   = empty_o ? '0 : mem_q[rd_idx];

   always_comb begin
      sp_d = sp_q;
      if (do_push) begin
         sp_d = sp_q + 1'b1;
      end else if (do_pop) begin
         sp_d = sp_q - 1'b1;
      end
   end

   always_ff @(posedge cp_i) begin
      if (rst_i) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entries are never cleared; reset only discards them via SP.
   always_ff @(posedge cp_i) begin
      if (!rst_i && do_push) begin
         mem_q[wr_idx] <= din_i;
      end
   end

`ifdef AM2909_SEQ_STACK_ERR_EN
   logic err_q;

   always_ff @(posedge cp_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if ((push_i && full_o) || (pop_i && empty_o)) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`endif

endmodule : am2909_seq_stack
`default_nettype wire

// File: rtl/am2909_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : am2909_seq
// Brief    : W-bit microprogram sequencer: source mux, OR/ZERO conditioning,
//            incrementer, AR, uPC and stack. ERR port with AM2909_SEQ_STACK_ERR_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module am2909_seq
   import am2909_seq_pkg::*;
#(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic         cp_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] r_i,
   input  logic         re_i,
   input  logic [1:0]   s_i,
   input  logic         fe_i,
   input  logic         pup_i,
   input  logic [W-1:0] or_i,
   input  logic         zero_i,
   input  logic         c_i,
   input  logic         oe_i,
   output logic [W-1:0] y_o,
   output logic         cout_o,
   output logic         full_o,
`ifdef AM2909_SEQ_STACK_ERR_EN
   output logic         err_o,
`endif
   output logic         empty_o
);

   logic [W-1:0] ar_q, ar_d;
   logic [W-1:0] upc_q, upc_d;
   logic [W-1:0] stk_top;
   logic [W-1:0] x_sel;
   logic [W-1:0] addr;
   logic [W:0]   inc_sum;
   logic         stk_push;
   logic         stk_pop;

   always_comb begin
      x_sel = upc_q;
      case (s_i)
         SRC_UPC: x_sel = upc_q;
         SRC_AR:  x_sel = ar_q;
         SRC_STK: x_sel = stk_top;
         SRC_D:   x_sel = d_i;
         default: x_sel = upc_q;
      endcase
   end

   assign addr    = zero_i ? (x_sel | or_i) : '0;
   assign inc_sum = {1'b0, addr} + {{W{1'b0}}, c_i};
   assign cout_o  = inc_sum[W];
   // Incrementer sees addr even while the bus is released.
   assign y_o     = oe_i ? {W{1'bz}} : addr;

   assign stk_push = ~fe_i & (pup_i == PUP_PUSH);
   assign stk_pop  = ~fe_i & (pup_i == PUP_POP);

   always_comb begin
      ar_d  = re_i ? ar_q : r_i;
      upc_d = inc_sum[W-1:0];
   end

   always_ff @(posedge cp_i) begin
      if (rst_i) begin
         ar_q  <= '0;
         upc_q <= '0;
      end else begin
         ar_q  <= ar_d;
         upc_q <= upc_d;
      end
   end

   am2909_seq_stack #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_stack (
      .cp_i    (cp_i),
      .rst_i   (rst_i),
      .push_i  (stk_push),
      .pop_i   (stk_pop),
      .din_i   (upc_q),
      .top_o   (stk_top),
      .full_o  (full_o),
`ifdef AM2909_SEQ_STACK_ERR_EN
      .err_o   (err_o),
`endif
      .empty_o (empty_o)
   );

endmodule : am2909_seq
`default_nettype wire

// File: tb/tb_am2909_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_am2909_seq
// Brief    : Directed and randomized checks of am2909_seq against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_am2909_seq;

   localparam int W     = 12;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst, re, fe, pup, zero, c, oe;
   logic [1:0]   s;
   logic [W-1:0] d, r, or_v;
   wire  [W-1:0] y;
   wire          cout, full, empty;
`ifdef AM2909_SEQ_STACK_ERR_EN
   wire          err;
`endif

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [W-1:0] m_upc, m_ar;
   logic [W-1:0] m_stk [$];
   logic         m_err;

   always #5 clk = ~clk;

   am2909_seq #(.W(W), .DEPTH(DEPTH)) dut (
      .cp_i    (clk),
      .rst_i   (rst),
      .d_i     (d),
      .r_i     (r),
      .re_i    (re),
      .s_i     (s),
      .fe_i    (fe),
      .pup_i   (pup),
      .or_i    (or_v),
      .zero_i  (zero),
      .c_i     (c),
      .oe_i    (oe),
      .y_o     (y),
      .cout_o  (cout),
      .full_o  (full),
`ifdef AM2909_SEQ_STACK_ERR_EN
      .err_o   (err),
`endif
      .empty_o (empty)
   );

   function automatic logic [W-1:0] m_addr();
      logic [W-1:0] x;
      case (s)
         2'd0:    x = m_upc;
         2'd1:    x = m_ar;
         2'd2:    x = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
         default: x = d;
      endcase
      return zero ? (x | or_v) : '0;
   endfunction

   task automatic m_clock();
      logic [W-1:0] a, old_upc;
      a       = m_addr();
      old_upc = m_upc;
      if (rst) begin
         m_upc = '0;
         m_ar  = '0;
         m_stk.delete();
         m_err = 1'b0;
      end else begin
         m_upc = W'((int'(a) + int'(c)) % (1 << W));
         if (!re) m_ar = r;
         if (!fe) begin
            if (pup) begin
               if (m_stk.size() < DEPTH) m_stk.push_back(old_upc);
               else m_err = 1'b1;
            end else begin
               if (m_stk.size() > 0) void'(m_stk.pop_back());
               else m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_clock();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s = 2'b00; c = 1'b1; or_v = '0; zero = 1'b1; oe = 1'b0; fe = 1'b1; re = 1'b1;
      #1;
      n_total++;
      if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty, full);
      else n_pass++;
`ifdef AM2909_SEQ_STACK_ERR_EN
      n_total++;
      if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
      else n_pass++;
`endif
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (y !== W'(i)) $display("FAIL incr_y%0d: got %h want %h", i, y, W'(i));
         else n_pass++;
         tick();
      end
      c = 1'b0;
      #1;
      n_total++;
      if (y !== 12'h004) $display("FAIL hold_y0: got %h want 004", y);
      else n_pass++;
      tick();
      n_total++;
      if (y !== 12'h004) $display("FAIL hold_y1: got %h want 004", y);
      else n_pass++;
   endtask

   task automatic test_wrap();
      s = 2'b11; d = 12'hFFF; c = 1'b1;
      #1;
      n_total++;
      if (cout !== 1'b1 || y !== 12'hFFF) $display("FAIL wrap_cout: got cout=%b y=%h want 1 fff", cout, y);
      else n_pass++;
      tick();
      s = 2'b00;
      #1;
      n_total++;
      if (y !== 12'h000 || cout !== 1'b0) $display("FAIL wrap_upc: got y=%h cout=%b want 000 0", y, cout);
      else n_pass++;
   endtask

   task automatic test_ar();
      s = 2'b01; re = 1'b0; r = 12'h2A5;
      #1;
      n_total++;
      if (y !== 12'h000) $display("FAIL ar_old: got %h want 000", y);
      else n_pass++;
      tick();
      re = 1'b1; r = 12'h111;
      #1;
      n_total++;
      if (y !== 12'h2A5) $display("FAIL ar_new: got %h want 2a5", y);
      else n_pass++;
      tick();
      n_total++;
      if (y !== 12'h2A5) $display("FAIL ar_hold: got %h want 2a5", y);
      else n_pass++;
   endtask

   task automatic test_call_return();
      s = 2'b11; d = 12'h00F; c = 1'b1; fe = 1'b1;
      tick();
      d = 12'h300; fe = 1'b0; pup = 1'b1;
      #1;
      n_total++;
      if (y !== 12'h300) $display("FAIL call_y: got %h want 300", y);
      else n_pass++;
      tick();
      fe = 1'b1; s = 2'b00;
      #1;
      n_total++;
      if (empty !== 1'b0 || full !== 1'b0) $display("FAIL call_sp: got empty=%b full=%b want 0 0", empty, full);
      else n_pass++;
      tick();
      tick();
      s = 2'b10; fe = 1'b0; pup = 1'b0;
      #1;
      n_total++;
      if (y !== 12'h010) $display("FAIL ret_y: got %h want 010", y);
      else n_pass++;
      tick();
      fe = 1'b1; s = 2'b00;
      #1;
      n_total++;
      if (y !== 12'h011 || empty !== 1'b1) $display("FAIL ret_upc: got y=%h empty=%b want 011 1", y, empty);
      else n_pass++;
   endtask

   task automatic test_stack_bounds();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         s = 2'b11; d = W'(k); c = 1'b0; fe = 1'b1;
         tick();
         fe = 1'b0; pup = 1'b1;
         tick();
         fe = 1'b1;
         #1;
         if (k >= 4) begin
            n_total++;
            if (full !== 1'b1) $display("FAIL full_after_push%0d: got %b want 1", k, full);
            else n_pass++;
         end
      end
`ifdef AM2909_SEQ_STACK_ERR_EN
      n_total++;
      if (err !== 1'b1) $display("FAIL err_overflow: got %b want 1", err);
      else n_pass++;
`endif
      s = 2'b10; fe = 1'b0; pup = 1'b0;
      for (int j = 4; j >= 1; j--) begin
         #1;
         n_total++;
         if (y !== W'(j)) $display("FAIL pop_top%0d: got %h want %h", j, y, W'(j));
         else n_pass++;
         tick();
      end
      #1;
      n_total++;
      if (empty !== 1'b1 || y !== 12'h000) $display("FAIL pop_empty: got empty=%b y=%h want 1 000", empty, y);
      else n_pass++;
      tick();
      fe = 1'b1;
      #1;
      n_total++;
      if (empty !== 1'b1 || full !== 1'b0) $display("FAIL underflow_sp: got empty=%b full=%b want 1 0", empty, full);
      else n_pass++;
   endtask

   task automatic test_conditioning();
      re = 1'b0; r = 12'h0F0; s = 2'b00; c = 1'b1;
      tick();
      re = 1'b1; s = 2'b01; or_v = 12'h00F;
      #1;
      n_total++;
      if (y !== 12'h0FF) $display("FAIL or_y: got %h want 0ff", y);
      else n_pass++;
      zero = 1'b0;
      #1;
      n_total++;
      if (y !== 12'h000) $display("FAIL zero_y: got %h want 000", y);
      else n_pass++;
      zero = 1'b1; or_v = '0; oe = 1'b1; s = 2'b11; d = 12'h123;
      tick();
      oe = 1'b0; s = 2'b00;
      #1;
      n_total++;
      if (y !== 12'h124) $display("FAIL oe_upc: got %h want 124", y);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [W-1:0] exp_y;
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 31) == 0);
         s    = 2'($urandom_range(0, 3));
         d    = W'($urandom);
         r    = W'($urandom);
         re   = 1'($urandom_range(0, 1));
         fe   = 1'($urandom_range(0, 1));
         pup  = 1'($urandom_range(0, 1));
         c    = 1'($urandom_range(0, 1));
         zero = ($urandom_range(0, 7) != 0);
         oe   = ($urandom_range(0, 7) == 0);
         or_v = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         if ($urandom_range(0, 15) == 0) d = '1;
         #1;
         exp_y = m_addr();
         if (!oe) begin
            n_total++;
            if (y !== exp_y) $display("FAIL rand_y[%0d]: got %h want %h", i, y, exp_y);
            else n_pass++;
         end
         n_total++;
         if (cout !== ((&exp_y) & c)) $display("FAIL rand_cout[%0d]: got %b want %b", i, cout, (&exp_y) & c);
         else n_pass++;
         n_total++;
         if (full !== (m_stk.size() == DEPTH) || empty !== (m_stk.size() == 0))
            $display("FAIL rand_flags[%0d]: got full=%b empty=%b want occupancy %0d", i, full, empty, m_stk.size());
         else n_pass++;
`ifdef AM2909_SEQ_STACK_ERR_EN
         n_total++;
         if (err !== m_err) $display("FAIL rand_err[%0d]: got %b want %b", i, err, m_err);
         else n_pass++;
`endif
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; re = 1'b1; fe = 1'b1; pup = 1'b0; zero = 1'b1; c = 1'b1; oe = 1'b0;
      s = 2'b00; d = '0; r = '0; or_v = '0;
      m_upc = '0; m_ar = '0; m_err = 1'b0;
      @(negedge clk);
      test_reset();
      test_wrap();
      test_ar();
      test_call_return();
      test_stack_bounds();
      test_conditioning();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_am2909_seq
`default_nettype wire
